// File: rtl/raster_cmd_pkg.sv
// Shared opcode/state encodings and payload lengths for the rasterizer command front-end.
package raster_cmd_pkg;

    typedef enum logic [7:0] {
        OP_NOP          = 8'h00,
        OP_SET_COLOR    = 8'h01,
        OP_SET_VIEWPORT = 8'h02,
        OP_DRAW_TRI     = 8'h03
    } op_e;

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_WAIT    = 2'd3
    } sched_st_e;

    localparam logic [31:0] VP_XMAX_DEF = 32'd639;
    localparam logic [31:0] VP_YMAX_DEF = 32'd479;

    function automatic logic is_legal_op(input logic [7:0] op);
        return (op == OP_NOP) || (op == OP_SET_COLOR) ||
               (op == OP_SET_VIEWPORT) || (op == OP_DRAW_TRI);
    endfunction

    function automatic logic [2:0] payload_len(input logic [7:0] op);
        case (op)
            OP_SET_COLOR:    return 3'd1;
            OP_SET_VIEWPORT: return 3'd4;
            OP_DRAW_TRI:     return 3'd6;
            default:         return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/raster_cmd_sched.sv
// Command parser + draw sequencer in front of the rasterizer.
// Optional busy-cycle counter enabled by defining RASTER_CMD_SCHED_PERF_EN.
module raster_cmd_sched
    import raster_cmd_pkg::*;
#(
    parameter int          TRI_CNT_W   = 16,
    parameter logic [31:0] VP_XMAX_RST = VP_XMAX_DEF,
    parameter logic [31:0] VP_YMAX_RST = VP_YMAX_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [31:0]          cmd_data,
    output logic                 rast_start,
    input  logic                 rast_done,
    output logic [31:0]          rast_x0,
    output logic [31:0]          rast_y0,
    output logic [31:0]          rast_x1,
    output logic [31:0]          rast_y1,
    output logic [31:0]          rast_x2,
    output logic [31:0]          rast_y2,
    output logic [31:0]          rast_color,
    output logic [31:0]          rast_vp_xmin,
    output logic [31:0]          rast_vp_ymin,
    output logic [31:0]          rast_vp_xmax,
    output logic [31:0]          rast_vp_ymax,
    output logic                 busy,
    output logic [TRI_CNT_W-1:0] tri_count,
    output logic                 err_illegal_op
`ifdef RASTER_CMD_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_busy_cycles
`endif
);

    sched_st_e             state_q, state_d;
    logic [7:0]            op_q, op_d;
    logic [2:0]            idx_q, idx_d;
    logic [31:0]           color_q, color_d;
    logic [3:0][31:0]      vp_q, vp_d;      // [0]=xmin [1]=ymin [2]=xmax [3]=ymax
    logic [5:0][31:0]      vtx_q, vtx_d;    // x0,y0,x1,y1,x2,y2 in payload order
    logic [TRI_CNT_W-1:0]  tri_q, tri_d;
    logic                  err_q, err_d;
    logic                  accept;
    logic [7:0]            hdr_op;

    assign cmd_ready = (state_q == ST_HDR) || (state_q == ST_PAYLOAD);
    assign accept    = cmd_valid && cmd_ready;
    assign hdr_op    = cmd_data[31:24];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        color_d = color_q;
        vp_d    = vp_q;
        vtx_d   = vtx_q;
        tri_d   = tri_q;
        err_d   = err_q;
        case (state_q)
            ST_HDR: begin
                if (accept) begin
                    if (!is_legal_op(hdr_op)) begin
                        err_d = 1'b1;
                    end else if (payload_len(hdr_op) != 3'd0) begin
                        op_d    = hdr_op;
                        idx_d   = 3'd0;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    // Payload words land straight in the live registers; no shadow copy.
                    case (op_q)
                        OP_SET_COLOR:    color_d = cmd_data;
                        OP_SET_VIEWPORT: vp_d[idx_q[1:0]] = cmd_data;
                        OP_DRAW_TRI:     vtx_d[idx_q] = cmd_data;
                        default:         ;
                    endcase
                    if (idx_q == payload_len(op_q) - 3'd1)
                        state_d = (op_q == OP_DRAW_TRI) ? ST_ISSUE : ST_HDR;
                    else
                        idx_d = idx_q + 3'd1;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (rast_done) begin
                    tri_d   = tri_q + 1'b1;
                    state_d = ST_HDR;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HDR;
            op_q    <= 8'h00;
            idx_q   <= 3'd0;
            color_q <= 32'h0;
            vp_q    <= {VP_YMAX_RST, VP_XMAX_RST, 32'h0, 32'h0};
            vtx_q   <= '0;
            tri_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            color_q <= color_d;
            vp_q    <= vp_d;
            vtx_q   <= vtx_d;
            tri_q   <= tri_d;
            err_q   <= err_d;
        end
    end

    assign rast_start     = (state_q == ST_ISSUE);
    assign busy           = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign rast_x0        = vtx_q[0];
    assign rast_y0        = vtx_q[1];
    assign rast_x1        = vtx_q[2];
    assign rast_y1        = vtx_q[3];
    assign rast_x2        = vtx_q[4];
    assign rast_y2        = vtx_q[5];
    assign rast_color     = color_q;
    assign rast_vp_xmin   = vp_q[0];
    assign rast_vp_ymin   = vp_q[1];
    assign rast_vp_xmax   = vp_q[2];
    assign rast_vp_ymax   = vp_q[3];
    assign tri_count      = tri_q;
    assign err_illegal_op = err_q;

`ifdef RASTER_CMD_SCHED_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (busy && (perf_q != 32'hFFFF_FFFF))
            perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= 32'h0;
        else        perf_q <= perf_d;
    end

    assign perf_busy_cycles = perf_q;
`endif

endmodule

// File: tb/tb_raster_cmd_sched.sv
// Directed self-checking bench for raster_cmd_sched with a stub rasterizer.
module tb_raster_cmd_sched;

    localparam int TW = 2;  // narrow counter so wrap is reachable quickly

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [31:0]   cmd_data = 32'h0;
    logic          cmd_ready, rast_start, rast_done, busy, err_illegal_op;
    logic [31:0]   rast_x0, rast_y0, rast_x1, rast_y1, rast_x2, rast_y2;
    logic [31:0]   rast_color, rast_vp_xmin, rast_vp_ymin, rast_vp_xmax, rast_vp_ymax;
    logic [TW-1:0] tri_count;
`ifdef RASTER_CMD_SCHED_PERF_EN
    logic [31:0]   perf_busy_cycles;
`endif

    raster_cmd_sched #(.TRI_CNT_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rast_start(rast_start), .rast_done(rast_done),
        .rast_x0(rast_x0), .rast_y0(rast_y0), .rast_x1(rast_x1),
        .rast_y1(rast_y1), .rast_x2(rast_x2), .rast_y2(rast_y2),
        .rast_color(rast_color),
        .rast_vp_xmin(rast_vp_xmin), .rast_vp_ymin(rast_vp_ymin),
        .rast_vp_xmax(rast_vp_xmax), .rast_vp_ymax(rast_vp_ymax),
        .busy(busy), .tri_count(tri_count), .err_illegal_op(err_illegal_op)
`ifdef RASTER_CMD_SCHED_PERF_EN
        , .perf_busy_cycles(perf_busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub rasterizer and activity monitor, both evaluated mid-cycle.
    logic         stub_done = 1'b0, man_done = 1'b0, vtx_bad = 1'b0;
    int           stub_cnt = 0, stub_delay = 20;
    int           start_cnt = 0, nrdy_cnt = 0, done_cyc = 0;
    logic [191:0] vtx_snap = '0;
    assign rast_done = stub_done | man_done;

    initial forever begin
        @(negedge clk);
        stub_done = 1'b0;
        if (!rst_n) stub_cnt = 0;
        else if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) stub_done = 1'b1;
        end else if (rast_start) stub_cnt = stub_delay;
        if (rast_start) begin
            start_cnt++;
            vtx_snap = {rast_x0, rast_y0, rast_x1, rast_y1, rast_x2, rast_y2};
        end
        if (busy && ({rast_x0, rast_y0, rast_x1, rast_y1, rast_x2, rast_y2} != vtx_snap))
            vtx_bad = 1'b1;
        if (!cmd_ready && rst_n) nrdy_cnt++;
        if (stub_done | man_done) done_cyc = cyc;
    end

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Present one word and hold it until accepted; returns at accept edge + 1.
    task automatic send(input logic [31:0] w);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_data  = w;
        while (!cmd_ready && n < 300) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) begin
            checks++;
            $display("FAIL send_timeout: word %0h never accepted", w);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 300) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) begin
            checks++;
            $display("FAIL ready_timeout: cmd_ready stuck at 0");
        end
    endtask

    task automatic draw(input logic [31:0] a, b, c, d, e, f);
        send(32'h0300_0000);
        send(a); send(b); send(c); send(d); send(e); send(f);
        cmd_valid = 1'b0;
        wait_ready();
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        man_done  = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [31:0]  w;
        logic [31:0]  color;
        logic [127:0] vp;
        logic         err;
    } vec_t;

    vec_t tbl[11];
    int   hdr_cyc;

    initial begin
        tbl[0]  = '{32'h0100_0000, 32'h0,         {32'h0, 32'h0, 32'd639, 32'd479}, 1'b0};
        tbl[1]  = '{32'hFF00_FF00, 32'hFF00_FF00, {32'h0, 32'h0, 32'd639, 32'd479}, 1'b0};
        tbl[2]  = '{32'h0000_0000, 32'hFF00_FF00, {32'h0, 32'h0, 32'd639, 32'd479}, 1'b0};
        tbl[3]  = '{32'h0200_0000, 32'hFF00_FF00, {32'h0, 32'h0, 32'd639, 32'd479}, 1'b0};
        tbl[4]  = '{32'h0000_0005, 32'hFF00_FF00, {32'h5, 32'h0, 32'd639, 32'd479}, 1'b0};
        tbl[5]  = '{32'h0000_0006, 32'hFF00_FF00, {32'h5, 32'h6, 32'd639, 32'd479}, 1'b0};
        tbl[6]  = '{32'h0000_0100, 32'hFF00_FF00, {32'h5, 32'h6, 32'h100, 32'd479}, 1'b0};
        tbl[7]  = '{32'h0000_0080, 32'hFF00_FF00, {32'h5, 32'h6, 32'h100, 32'h80}, 1'b0};
        tbl[8]  = '{32'h7F00_0000, 32'hFF00_FF00, {32'h5, 32'h6, 32'h100, 32'h80}, 1'b1};
        tbl[9]  = '{32'h0100_0000, 32'hFF00_FF00, {32'h5, 32'h6, 32'h100, 32'h80}, 1'b1};
        tbl[10] = '{32'h1234_5678, 32'h1234_5678, {32'h5, 32'h6, 32'h100, 32'h80}, 1'b1};

        do_reset();
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_start", rast_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_vp", {rast_vp_xmin, rast_vp_ymin, rast_vp_xmax, rast_vp_ymax},
            {32'h0, 32'h0, 32'd639, 32'd479});
        chk("rst_tri", tri_count, 0);
        chk("rst_err", err_illegal_op, 1'b0);
        chk("rst_color", rast_color, 32'h0);

        start_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            send(tbl[i].w);
            cmd_valid = 1'b0;
            chk($sformatf("tbl%0d_color", i), rast_color, tbl[i].color);
            chk($sformatf("tbl%0d_vp", i),
                {rast_vp_xmin, rast_vp_ymin, rast_vp_xmax, rast_vp_ymax}, tbl[i].vp);
            chk($sformatf("tbl%0d_err", i), err_illegal_op, tbl[i].err);
            chk($sformatf("tbl%0d_ready", i), cmd_ready, 1'b1);
        end
        chk("tbl_no_start", start_cnt, 0);
`ifdef RASTER_CMD_SCHED_PERF_EN
        chk("perf_idle", perf_busy_cycles, 0);
`endif

        // Single draw: start the cycle after the sixth vertex, 21 stalled cycles.
        start_cnt = 0; nrdy_cnt = 0; vtx_bad = 1'b0; stub_delay = 20;
        send(32'h0300_0000);
        send(2); send(3); send(10); send(3); send(6); send(9);
        cmd_valid = 1'b0;
        chk("draw_start_latency", rast_start, 1'b1);
        chk("draw_busy", busy, 1'b1);
        chk("draw_ready_low", cmd_ready, 1'b0);
        wait_ready();
        chk("draw_nrdy_cycles", nrdy_cnt, 21);
        chk("draw_start_once", start_cnt, 1);
        chk("draw_vtx_stable", vtx_bad, 1'b0);
        chk("draw_vtx", {rast_x0, rast_y0, rast_x1, rast_y1, rast_x2, rast_y2},
            {32'd2, 32'd3, 32'd10, 32'd3, 32'd6, 32'd9});
        chk("draw_tri", tri_count, 1);
        chk("err_sticky", err_illegal_op, 1'b1);
`ifdef RASTER_CMD_SCHED_PERF_EN
        chk("perf_draw", perf_busy_cycles, 21);
`endif
        repeat (5) @(posedge clk);
        #1 chk("draw_no_extra_start", start_cnt, 1);

        // Back-to-back draws with valid held high.
        do_reset();
        start_cnt = 0;
        send(32'h0300_0000);
        send(1); send(2); send(3); send(4); send(5); send(6);
        send(32'h0300_0000);
        hdr_cyc = cyc;
        chk("b2b_hdr_after_done", hdr_cyc - done_cyc, 2);
        send(7); send(8); send(9); send(10); send(11); send(12);
        cmd_valid = 1'b0;
        wait_ready();
        chk("b2b_tri", tri_count, 2);
        chk("b2b_starts", start_cnt, 2);
        chk("b2b_vtx", {rast_x0, rast_y2}, {32'd7, 32'd12});

        // Counter wrap: 2 more draws take the 2-bit count from 2 through 3 to 0.
        stub_delay = 2;
        draw(0, 0, 1, 1, 2, 2);
        chk("tri_three", tri_count, 3);
        draw(0, 0, 1, 1, 2, 2);
        chk("tri_wrap", tri_count, 0);

        // Done pulse while idle is ignored.
        start_cnt = 0;
        @(negedge clk); man_done = 1'b1;
        @(negedge clk); man_done = 1'b0;
        @(posedge clk); #1;
        chk("spur_tri", tri_count, 0);
        chk("spur_ready", cmd_ready, 1'b1);
        chk("spur_busy", busy, 1'b0);

        // Reset while waiting on the rasterizer.
        stub_delay = 20; start_cnt = 0;
        send(32'h5500_0000);
        send(32'h0100_0000); send(32'hCAFE_F00D);
        chk("pre_rst_err", err_illegal_op, 1'b1);
        send(32'h0300_0000);
        send(32'hAAAA_AAAA); send(1); send(2); send(3); send(4); send(5);
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("pre_rst_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_start", rast_start, 1'b0);
        chk("arst_x0", rast_x0, 32'h0);
        chk("arst_color", rast_color, 32'h0);
        chk("arst_vp", {rast_vp_xmax, rast_vp_ymax}, {32'd639, 32'd479});
        chk("arst_err", err_illegal_op, 1'b0);
        chk("arst_tri", tri_count, 0);
`ifdef RASTER_CMD_SCHED_PERF_EN
        chk("arst_perf", perf_busy_cycles, 0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("post_rst_ready", cmd_ready, 1'b1);
        chk("post_rst_no_start", start_cnt, 1);
        chk("post_rst_tri", tri_count, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
